// File: rtl/reg_sequencer.sv
// Command sequencer for the 4-bit clear/load/inc/dec/shift register.
// It turns one accepted command into a run of single-function control pulses and then a done pulse.
module reg_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [W-1:0]     reg_q,
  output logic             cl,
  output logic             ld,
  output logic             inc,
  output logic             dec,
  output logic             sr,
  output logic             sl,
  output logic             ir,
  output logic             il,
  output logic [W-1:0]     ld_data,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [W-1:0]       arg_q, arg_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  // Only the end bits of reg_q feed rotation; the rest are intentionally ignored.
  logic reg_q_unused;
  assign reg_q_unused = ^reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_CLR;
      arg_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    rem_d     = rem_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cl        = 1'b0;
    ld        = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    sr        = 1'b0;
    sl        = 1'b0;
    ir        = 1'b0;
    il        = 1'b0;
    ld_data   = arg_q;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          op_d  = cmd_op;
          arg_d = cmd_arg;
          if (cmd_op == OP_CLR || cmd_op == OP_LOAD) begin
            rem_d   = CNT_W'(1);
            state_d = EXEC;
          end else if (cmd_cnt != '0) begin
            rem_d   = cmd_cnt;
            state_d = EXEC;
          end else begin
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end

      EXEC: begin
        // Controls depend only on registered state so the sole input-to-output path is the rotate feedback.
        case (op_q)
          OP_CLR:         cl  = 1'b1;
          OP_LOAD:        ld  = 1'b1;
          OP_INC:         inc = 1'b1;
          OP_DEC:         dec = 1'b1;
          OP_SHR, OP_ROR: sr  = 1'b1;
          default:        sl  = 1'b1;
        endcase
        ir    = (op_q == OP_ROR) ? reg_q[0]   : 1'b0;
        il    = (op_q == OP_ROL) ? reg_q[W-1] : 1'b0;
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Keep the unused opcode names referenced for readers of the decode above.
  logic op_names_unused;
  assign op_names_unused = ^{OP_SHL, OP_ROL};

endmodule
